// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 3-stage IEEE-754 adder/subtractor with rounding and flags.
// Define FP_STICKY_FLAGS_EN to build the accumulated sticky-flag register.
module fp_addsub_pipe #(
  parameter int EXP_WIDTH      = 5,
  parameter int MANT_WIDTH     = 10,
  parameter int NUM_ROUND_BITS = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [EXP_WIDTH+MANT_WIDTH:0]     a,
  input  logic [EXP_WIDTH+MANT_WIDTH:0]     b,
  input  logic                              op,
  input  logic [1:0]                        rm,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [EXP_WIDTH+MANT_WIDTH:0]     result,
  output logic [3:0]                        flags,
  output logic [3:0]                        flags_sticky,
  input  logic                              flags_clr
);

  localparam int NUM_BITS = 1 + EXP_WIDTH + MANT_WIDTH;
  localparam int BIAS = 2 ** (EXP_WIDTH - 1) - 1;
  localparam int E  = EXP_WIDTH;
  localparam int M  = MANT_WIDTH;
  localparam int R  = NUM_ROUND_BITS;
  localparam int W  = M + R + 1;
  localparam int XW = E + 2;
  localparam int LW = $clog2(W + 1);

  // biased encoding of the subnormal exponent 1-BIAS
  localparam logic [E-1:0] EMIN_B = E'(BIAS + 1 - BIAS);
  localparam logic [E-1:0] EALL = {E{1'b1}};
  localparam logic [NUM_BITS-1:0] QNAN =
    {1'b0, EALL, 1'b1, {(M-1){1'b0}}};

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RDN = 2'b10;
  localparam logic [1:0] RM_RUP = 2'b11;

  typedef struct packed {
    logic                special;
    logic                sinv;
    logic [NUM_BITS-1:0] sres;
    logic                big_s;
    logic                lit_s;
    logic [E-1:0]        exp;
    logic [W-1:0]        big;
    logic [W-1:0]        lit;
    logic [1:0]          rm;
  } s1_t;

  typedef struct packed {
    logic                special;
    logic                sinv;
    logic [NUM_BITS-1:0] sres;
    logic                sign;
    logic                zsign;
    logic [E-1:0]        exp;
    logic [W:0]          sum;
    logic [1:0]          rm;
  } s2_t;

  logic stall;
  logic s1_vq, s2_vq, out_vq;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  logic [NUM_BITS-1:0] res_d, res_q;
  logic [3:0] flg_d, flg_q;

  assign stall     = out_vq & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = out_vq;
  assign result    = res_q;
  assign flags     = flg_q;

  logic         a_s, b_s;
  logic [E-1:0] a_e, b_e;
  logic [M-1:0] a_f, b_f;
  logic a_inf, b_inf, a_nan, b_nan, a_snan, b_snan, inf_inv;

  assign a_s = a[NUM_BITS-1];
  assign b_s = b[NUM_BITS-1] ^ op;
  assign a_e = a[NUM_BITS-2:M];
  assign b_e = b[NUM_BITS-2:M];
  assign a_f = a[M-1:0];
  assign b_f = b[M-1:0];
  assign a_inf  = (&a_e) & ~(|a_f);
  assign b_inf  = (&b_e) & ~(|b_f);
  assign a_nan  = (&a_e) & (|a_f);
  assign b_nan  = (&b_e) & (|b_f);
  assign a_snan = a_nan & ~a_f[M-1];
  assign b_snan = b_nan & ~b_f[M-1];
  assign inf_inv = a_inf & b_inf & (a_s ^ b_s);

  logic         swap;
  logic [E-1:0] a_ee, b_ee, big_e, lit_e, diff;
  logic [M:0]   a_m, b_m, lit_m;
  logic [2*W-1:0] lit_sh;

  always_comb begin
    a_ee  = (a_e == '0) ? EMIN_B : a_e;
    b_ee  = (b_e == '0) ? EMIN_B : b_e;
    a_m   = {|a_e, a_f};
    b_m   = {|b_e, b_f};
    swap  = b[NUM_BITS-2:0] > a[NUM_BITS-2:0];
    big_e = swap ? b_ee : a_ee;
    lit_e = swap ? a_ee : b_ee;
    lit_m = swap ? a_m : b_m;
    diff  = big_e - lit_e;
    lit_sh = {lit_m, {(R+W){1'b0}}} >> diff;
    s1_d = '0;
    s1_d.big_s = swap ? b_s : a_s;
    s1_d.lit_s = swap ? a_s : b_s;
    s1_d.exp   = big_e;
    s1_d.big   = {swap ? b_m : a_m, {R{1'b0}}};
    if (int'(diff) >= W)
      s1_d.lit = {{(W-1){1'b0}}, |lit_m};
    else
      s1_d.lit = lit_sh[2*W-1:W] |
                 {{(W-1){1'b0}}, |lit_sh[W-1:0]};
    s1_d.rm      = rm;
    s1_d.special = a_nan | b_nan | a_inf | b_inf;
    s1_d.sinv    = a_snan | b_snan | inf_inv;
    if (a_nan | b_nan | inf_inv)
      s1_d.sres = QNAN;
    else if (a_inf)
      s1_d.sres = {a_s, EALL, {M{1'b0}}};
    else
      s1_d.sres = {b_s, EALL, {M{1'b0}}};
  end

  logic eff_sub;

  always_comb begin
    s2_d = '0;
    eff_sub = s1_q.big_s ^ s1_q.lit_s;
    s2_d.special = s1_q.special;
    s2_d.sinv    = s1_q.sinv;
    s2_d.sres    = s1_q.sres;
    s2_d.sign    = s1_q.big_s;
    s2_d.zsign   = eff_sub ? (s1_q.rm == RM_RDN) : s1_q.big_s;
    s2_d.exp     = s1_q.exp;
    s2_d.rm      = s1_q.rm;
    s2_d.sum     = eff_sub ? {1'b0, s1_q.big} - {1'b0, s1_q.lit}
                           : {1'b0, s1_q.big} + {1'b0, s1_q.lit};
  end

  logic [W-1:0]  m;
  logic [XW-1:0] e, ef, shamt;
  logic [LW-1:0] lz;
  logic [M+1:0]  mr;
  logic [M-1:0]  fr;
  logic g, st, inx, inc, ofl, to_inf, uf;

  always_comb begin
    lz = LW'(W);
    for (int i = 0; i < W; i++)
      if (s2_q.sum[i]) lz = LW'(W - 1 - i);
    e = XW'(s2_q.exp);
    shamt = '0;
    if (s2_q.sum[W]) begin
      m = s2_q.sum[W:1] | {{(W-1){1'b0}}, s2_q.sum[0]};
      e = e + XW'(1);
    end else begin
      // stop at the minimum exponent, leaving a subnormal
      shamt = (XW'(lz) < e) ? XW'(lz) : e - XW'(1);
      m = s2_q.sum[W-1:0] << shamt;
      e = e - shamt;
    end
    g   = m[R-1];
    st  = |m[R-2:0];
    inx = g | st;
    inc = 1'b0;
    unique case (1'b1)
      s2_q.rm == RM_RNE: inc = g & (st | m[R]);
      s2_q.rm == RM_RTZ: inc = 1'b0;
      s2_q.rm == RM_RDN: inc = s2_q.sign & inx;
      s2_q.rm == RM_RUP: inc = ~s2_q.sign & inx;
    endcase
    mr = {1'b0, m[W-1:R]} + (M+2)'(inc);
    if (mr[M+1]) begin
      ef = e + XW'(1);
      fr = mr[M:1];
    end else begin
      ef = mr[M] ? e : '0;
      fr = mr[M-1:0];
    end
    ofl = ef >= XW'(EALL);
    uf  = (ef == '0) & inx;
    to_inf = (s2_q.rm == RM_RNE) |
             ((s2_q.rm == RM_RUP) & ~s2_q.sign) |
             ((s2_q.rm == RM_RDN) & s2_q.sign);
    res_d = '0;
    flg_d = '0;
    if (s2_q.special) begin
      res_d = s2_q.sres;
      flg_d = {s2_q.sinv, 3'b000};
    end else if (s2_q.sum == '0) begin
      res_d = {s2_q.zsign, {(NUM_BITS-1){1'b0}}};
    end else if (ofl) begin
      res_d = to_inf ? {s2_q.sign, EALL, {M{1'b0}}}
                     : {s2_q.sign, EALL - E'(1), {M{1'b1}}};
      flg_d = 4'b0101;
    end else begin
      res_d = {s2_q.sign, ef[E-1:0], fr};
      flg_d = {2'b00, uf, inx};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vq  <= 1'b0;
      s2_vq  <= 1'b0;
      out_vq <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
      res_q  <= '0;
      flg_q  <= '0;
    end else if (!stall) begin
      s1_vq  <= in_valid;
      s2_vq  <= s1_vq;
      out_vq <= s2_vq;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      if (s2_vq) begin
        res_q <= res_d;
        flg_q <= flg_d;
      end
    end
  end

`ifdef FP_STICKY_FLAGS_EN
  logic [3:0] sticky_d, sticky_q;

  always_comb begin
    sticky_d = sticky_q;
    if (flags_clr)
      sticky_d = '0;
    else if (out_vq & out_ready)
      sticky_d = sticky_q | flg_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_q <= '0;
    else     sticky_q <= sticky_d;
  end

  assign flags_sticky = sticky_q;
`else
  logic unused_clr;
  assign unused_clr   = flags_clr;
  assign flags_sticky = '0;
`endif

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: random + directed scoreboard bench for fp_addsub_pipe.
// Reference model works on exact integer values in units of the min subnormal.
module tb_fp_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        op = 1'b0;
  logic [1:0]  rm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] result;
  logic [3:0]  flags;
  logic [3:0]  flags_sticky;
  logic        flags_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] r;
    logic [3:0]  f;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  exp_t q[$];
  int   bp_req = 0;
  int   bp_done = 0;
  int   clr_req = 0;
  int   clr_seen = 0;
  bit   bp_rand = 0;
  bit   clr_rand = 0;
  logic [3:0] sticky_m = '0;

  always #5 clk = ~clk;

  fp_addsub_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .rm(rm),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags),
    .flags_sticky(flags_sticky), .flags_clr(flags_clr)
  );

  function automatic void check(string nm, logic [31:0] act,
                                logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, expv, $time);
    end
  endfunction

  function automatic longint mag(logic [15:0] x);
    if (x[14:10] == 5'd0) return longint'(x[9:0]);
    return longint'(1024 + int'(x[9:0])) << (int'(x[14:10]) - 1);
  endfunction

  function automatic void model(input logic [15:0] x, y, input logic o,
                                input logic [1:0] md,
                                output logic [15:0] r,
                                output logic [3:0] f);
    bit sx, sy, xn, yn, xs, ys, xi, yi, ii, neg, up, inx;
    longint s, aa, qq, rem, half;
    int k, ef;
    sx = x[15];
    sy = y[15] ^ o;
    xn = (x[14:10] == 5'h1F) && (x[9:0] != 0);
    yn = (y[14:10] == 5'h1F) && (y[9:0] != 0);
    xs = xn && !x[9];
    ys = yn && !y[9];
    xi = (x[14:10] == 5'h1F) && (x[9:0] == 0);
    yi = (y[14:10] == 5'h1F) && (y[9:0] == 0);
    ii = xi && yi && (sx != sy);
    r = '0;
    f = '0;
    if (xn || yn || ii) begin
      r = 16'h7E00;
      f = {xs || ys || ii, 3'b000};
      return;
    end
    if (xi) begin r = {sx, 15'h7C00}; return; end
    if (yi) begin r = {sy, 15'h7C00}; return; end
    s = (sx ? -mag(x) : mag(x)) + (sy ? -mag(y) : mag(y));
    if (s == 0) begin
      if (mag(x) == 0 && mag(y) == 0 && sx == sy) r = {sx, 15'h0};
      else r = {md == 2'b10, 15'h0};
      return;
    end
    neg = s < 0;
    aa = neg ? -s : s;
    k = 0;
    while ((aa >> k) >= 2048) k++;
    qq = aa >> k;
    rem = aa - (qq << k);
    half = (k > 0) ? (longint'(1) << (k - 1)) : 0;
    inx = rem != 0;
    case (md)
      2'b00: up = (rem > half) || (inx && rem == half && qq[0]);
      2'b01: up = 0;
      2'b10: up = neg && inx;
      default: up = !neg && inx;
    endcase
    if (up) qq++;
    if (qq == 2048) begin qq = 1024; k++; end
    ef = (qq >= 1024) ? k + 1 : 0;
    if (qq >= 1024) qq -= 1024;
    if (ef >= 31) begin
      if (md == 2'b00 || (md == 2'b11 && !neg) || (md == 2'b10 && neg))
        r = {neg, 15'h7C00};
      else
        r = {neg, 15'h7BFF};
      f = 4'b0101;
    end else begin
      r = {neg, 5'(ef), 10'(qq)};
      f = {2'b00, ef == 0 && inx, inx};
    end
  endfunction

  task automatic send(input logic [15:0] ta, tb, input logic top,
                      input logic [1:0] trm, input logic [15:0] er,
                      input logic [3:0] efl);
    exp_t e;
    int n;
    @(negedge clk);
    a = ta; b = tb; op = top; rm = trm;
    in_valid = 1'b1;
    e.r = er; e.f = efl; e.a = ta; e.b = tb;
    n = 0;
    do begin @(posedge clk); n++; end while (!in_ready && n < 100);
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    else q.push_back(e);
  endtask

  task automatic send_rand(input logic [15:0] ta, tb, input logic top,
                           input logic [1:0] trm);
    logic [15:0] r;
    logic [3:0] f;
    model(ta, tb, top, trm, r, f);
    send(ta, tb, top, trm, r, f);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  function automatic logic [15:0] pick();
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom_range(0, 9))
      0: v = {v[15], 15'h0};
      1: v = {v[15], 5'h1F, 10'h0};
      2: v = {v[15], 5'h1F, v[9:0] | 10'h1};
      3: v = {v[15], 5'h0, v[9:0]};
      4: v = {v[15], 5'h1E, v[9:0]};
      default: ;
    endcase
    return v;
  endfunction

  // monitor: drives the consumer side and scores every handshake
  initial begin
    exp_t e;
    bit hs;
    forever begin
      @(negedge clk);
      if (bp_done < bp_req) begin
        out_ready = 1'b0;
        bp_done++;
      end else if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
      else out_ready = 1'b1;
      flags_clr = (clr_seen != clr_req) ||
                  (clr_rand && $urandom_range(0, 15) == 0);
      clr_seen = clr_req;
      #1;
      if (rst) begin
        q.delete();
        sticky_m = '0;
      end else begin
        check("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
`ifdef FP_STICKY_FLAGS_EN
        check("flags_sticky", 32'(flags_sticky), 32'(sticky_m));
`else
        check("flags_sticky_zero", 32'(flags_sticky), 32'd0);
`endif
        hs = out_valid && out_ready;
        e.f = '0;
        if (hs) begin
          if (q.size() == 0) begin
            check("spurious_out", 32'(result), 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            if (result !== e.r || flags !== e.f)
              $display("  operands a=%h b=%h", e.a, e.b);
            check("result", 32'(result), 32'(e.r));
            check("flags", 32'(flags), 32'(e.f));
          end
        end
        if (flags_clr) sticky_m = '0;
        else if (hs) sticky_m = sticky_m | e.f;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int n;
    logic [15:0] ra, rb;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_sticky", 32'(flags_sticky), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    send(16'h3C00, 16'h4000, 0, 2'b00, 16'h4200, 4'b0000);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) in_valid = 1'b0;
      #2;
    end while (!out_valid && lat < 20);
    check("latency", 32'(lat), 32'd3);

    send(16'h3C00, 16'h3C00, 1, 2'b00, 16'h0000, 4'b0000);
    send(16'h3C00, 16'h3C00, 1, 2'b10, 16'h8000, 4'b0000);
    send(16'h7BFF, 16'h7BFF, 0, 2'b00, 16'h7C00, 4'b0101);
    send(16'h7BFF, 16'h7BFF, 0, 2'b01, 16'h7BFF, 4'b0101);
    send(16'h3C00, 16'h1000, 0, 2'b00, 16'h3C00, 4'b0001);
    send(16'h3C00, 16'h1000, 0, 2'b11, 16'h3C01, 4'b0001);
    send(16'h0001, 16'h0001, 0, 2'b00, 16'h0002, 4'b0000);
    send(16'h7C00, 16'h7C00, 1, 2'b00, 16'h7E00, 4'b1000);
    send(16'h7D00, 16'h3C00, 0, 2'b00, 16'h7E00, 4'b1000);
    send(16'h8000, 16'h8000, 0, 2'b00, 16'h8000, 4'b0000);
    send(16'h7E00, 16'h3C00, 0, 2'b01, 16'h7E00, 4'b0000);
    send(16'hFC00, 16'h3C00, 0, 2'b11, 16'hFC00, 4'b0000);
    idle();
    repeat (6) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      send_rand(pick(), pick(), 1'($urandom), 2'($urandom));
      if (i == 3) bp_req += 5;
    end
    idle();
    repeat (12) @(negedge clk);

    for (int i = 0; i < 6; i++)
      send_rand(16'h3C00, 16'h1000, 0, 2'b00);
    clr_req++;
    for (int i = 0; i < 4; i++)
      send_rand(16'h3C00, 16'h1000, 0, 2'b00);
    idle();
    repeat (6) @(negedge clk);

    bp_rand = 1;
    clr_rand = 1;
    for (int i = 0; i < 400; i++) begin
      ra = pick();
      rb = ($urandom_range(0, 3) == 0) ? (ra ^ 16'($urandom_range(0, 7)))
                                       : pick();
      send_rand(ra, rb, 1'($urandom), 2'($urandom));
      if ($urandom_range(0, 7) == 0) idle();
    end
    idle();

    for (int i = 0; i < 4; i++)
      send_rand(pick(), pick(), 1'($urandom), 2'($urandom));
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    #2;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    #2;
    check("midrst_out_valid2", 32'(out_valid), 32'd0);
    check("midrst_sticky", 32'(flags_sticky), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bp_rand = 0;
    clr_rand = 0;

    for (int i = 0; i < 20; i++)
      send_rand(pick(), pick(), 1'($urandom), 2'($urandom));
    idle();

    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(q.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
